// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter (div_share_arb).
// Optional watchdog in the top is enabled with DIV_ARB_TIMEOUT_EN.
package div_arb_pkg;

    localparam int unsigned DATAWIDTH_DEF = 57;

    // Wide enough for any supported operand width; narrowed with a sized cast at use.
    localparam int unsigned QUOT_DIV0_W = 64;
    localparam logic [QUOT_DIV0_W-1:0] QUOT_DIV0 = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Bit width of the round-robin pointer for a given requester count.
    function automatic int unsigned rr_ptr_w(input int unsigned nreq);
        int unsigned w;
        w = 1;
        if (nreq > 2) begin
            w = $clog2(nreq);
        end
        return w;
    endfunction

endpackage

// File: rtl/div_share_arb_if.sv
// Requester and divider handshake bundle of div_share_arb.
// master: the arbiter side; slave: the requesters plus the divider.
interface div_share_arb_if #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned DATAWIDTH = div_arb_pkg::DATAWIDTH_DEF
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ*DATAWIDTH-1:0] req_dividend;
    logic [NREQ*DATAWIDTH-1:0] req_divisor;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0]           rsp_valid;
    logic [DATAWIDTH-1:0]      rsp_quotient;
    logic [DATAWIDTH-1:0]      rsp_remainder;
    logic                      rsp_err;
    logic                      div_en;
    logic [DATAWIDTH-1:0]      div_dividend;
    logic [DATAWIDTH-1:0]      div_divisor;
    logic                      div_ready;
    logic [DATAWIDTH-1:0]      div_quotient;
    logic [DATAWIDTH-1:0]      div_remainder;
    logic                      div_vld;

    modport master (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
        output div_en, div_dividend, div_divisor,
        input  div_ready, div_quotient, div_remainder, div_vld
    );

    modport slave (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
        input  div_en, div_dividend, div_divisor,
        output div_ready, div_quotient, div_remainder, div_vld
    );
endinterface

// File: rtl/div_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Reusable for any shared resource; gnt is one-hot, found flags a non-empty request set.
module div_rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          found
);
    logic [2*N-1:0] w_dbl_req;
    logic [2*N-1:0] w_dbl_gnt;
    logic [N-1:0]   w_rot_req;
    logic [N-1:0]   w_rot_gnt;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        w_dbl_req = {req, req} >> ptr;
        w_rot_req = w_dbl_req[N-1:0];
        w_rot_gnt = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && w_rot_req[k]) begin
                w_rot_gnt[k] = 1'b1;
                found        = 1'b1;
            end
        end
        w_dbl_gnt = {w_rot_gnt, w_rot_gnt} << ptr;
        gnt       = w_dbl_gnt[2*N-1:N];
    end

endmodule

// File: rtl/div_share_arb.sv
// Round-robin arbiter sharing one multi-cycle divider among NREQ requesters.
// Define DIV_ARB_TIMEOUT_EN to add a watchdog that answers with err after TIMEOUT_CYC.
module div_share_arb
    import div_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned DATAWIDTH   = DATAWIDTH_DEF,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input logic             sys_clk,
    input logic             sys_rst,
    div_share_arb_if.master bus
);
    localparam int unsigned PW = rr_ptr_w(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC == 0) begin : g_param_chk
        $error("div_share_arb: NREQ must be 2..8 and TIMEOUT_CYC nonzero");
    end

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_wd_cnt;
`endif

    arb_state_e           r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        w_next_ptr;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      w_gnt;
    logic                 w_found;
    logic [NREQ-1:0]      r_rsp_valid;
    logic [DATAWIDTH-1:0] r_dividend;
    logic [DATAWIDTH-1:0] r_divisor;
    logic [DATAWIDTH-1:0] w_sel_a;
    logic [DATAWIDTH-1:0] w_sel_b;
    logic [DATAWIDTH-1:0] r_rsp_q;
    logic [DATAWIDTH-1:0] r_rsp_r;
    logic                 r_rsp_err;

    div_rr_pick #(
        .N (NREQ),
        .PW(PW)
    ) u_pick (
        .req  (bus.req_valid),
        .ptr  (r_ptr),
        .gnt  (w_gnt),
        .found(w_found)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = bus.req_dividend[i*DATAWIDTH +: DATAWIDTH];
                w_sel_b = bus.req_divisor[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Requester just served drops to lowest priority.
    always_comb begin
        w_next_ptr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Accept and start are same-cycle pulses, gated so nothing leaves during reset.
    assign bus.req_ready     = (r_state == ST_IDLE && !sys_rst) ? w_gnt : '0;
    assign bus.div_en        = (r_state == ST_ISSUE) && bus.div_ready;
    assign bus.div_dividend  = r_dividend;
    assign bus.div_divisor   = r_divisor;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_quotient  = r_rsp_q;
    assign bus.rsp_remainder = r_rsp_r;
    assign bus.rsp_err       = r_rsp_err;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_err   <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            r_wd_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt      <= w_gnt;
                        r_dividend <= w_sel_a;
                        r_divisor  <= w_sel_b;
                        // Divide-by-zero is answered locally; the divider is never started.
                        if (w_sel_b == '0) begin
                            r_rsp_q     <= DATAWIDTH'(QUOT_DIV0);
                            r_rsp_r     <= w_sel_a;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= w_gnt;
                            r_state     <= ST_RESP;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.div_ready) begin
                        r_state  <= ST_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
                        r_wd_cnt <= CW'(1);
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus.div_vld) begin
                        r_rsp_q     <= bus.div_quotient;
                        r_rsp_r     <= bus.div_remainder;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= r_gnt;
                        r_state     <= ST_RESP;
                    end
`ifdef DIV_ARB_TIMEOUT_EN
                    else if (r_wd_cnt >= CW'(TIMEOUT_CYC)) begin
                        r_rsp_q     <= '0;
                        r_rsp_r     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_gnt;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CW'(1);
                    end
`endif
                end
                ST_RESP: begin
                    r_rsp_valid <= '0;
                    r_ptr       <= w_next_ptr;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_share_arb.md
# div_share_arb

Round-robin arbiter and sequencer that shares one multi-cycle `div_fsm` divider among several requesters in the cymometer datapath. Typical requesters are the frequency computation, which divides a scaled reference count by the measured count, and the period/duty computations. The block accepts one division request at a time and issues it to the divider with the divider's `en/ready/vld_out` handshake. It returns the result to the granted requester as a one-cycle response pulse. Divide-by-zero is short-circuited locally, and an optional watchdog recovers from a divider that never answers.

## Interface
- `NREQ`, 2, number of requesters (2..8)
- `DATAWIDTH`, 57, operand and result width
- `TIMEOUT_CYC`, 256, watchdog limit in cycles from `div_en` to `div_vld` (used only with `DIV_ARB_TIMEOUT_EN`)

Ports:
- `sys_clk`  in  1  single clock for the block
- `sys_rst`  in  1  asynchronous reset, active-high
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_dividend`  in  NREQ*DATAWIDTH  packed dividends; requester i occupies slice i
- `req_divisor`  in  NREQ*DATAWIDTH  packed divisors
- `req_ready`  out  NREQ  one-hot accept pulse
- `rsp_valid`  out  NREQ  one-hot result pulse
- `rsp_quotient`  out  DATAWIDTH  result quotient
- `rsp_remainder`  out  DATAWIDTH  result remainder
- `rsp_err`  out  1  result is a divide-by-zero or timeout; qualified by `rsp_valid`
- `div_en`  out  1  start pulse to the divider
- `div_dividend`  out  DATAWIDTH  registered operand to the divider
- `div_divisor`  out  DATAWIDTH  registered operand to the divider
- `div_ready`  in  1  divider idle
- `div_quotient`  in  DATAWIDTH  divider result
- `div_remainder`  in  DATAWIDTH  divider result
- `div_vld`  in  1  divider result-valid pulse

## Operation
- **Reset values:** all outputs are 0, the FSM is in IDLE and `rr_ptr` is 0.
- **Requester rule:** a requester holds `req_valid` and its operands stable until it sees its `req_ready` pulse.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - When any `req_valid` is high, pick the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - Register the winner's operands into `div_dividend`/`div_divisor` and pulse `req_ready[g]`.
  - If the divisor is 0, go to RESP with quotient all-ones, remainder = dividend and err = 1. Otherwise go to ISSUE.
- **ISSUE:** wait for `div_ready`=1, then pulse `div_en` for one cycle and go to WAIT.
- **WAIT:** on `div_vld`, capture `div_quotient`/`div_remainder`, set err = 0 and go to RESP.
- **RESP:**
  - Pulse `rsp_valid[g]` for one cycle, with `rsp_quotient`/`rsp_remainder`/`rsp_err` registered.
  - `rsp_quotient`/`rsp_remainder`/`rsp_err` hold their values until the next response.
  - Set `rr_ptr` = (g+1) mod NREQ and go to IDLE.
- **Fairness:** the requester just served has lowest priority on the next arbitration. Each requester is served at most once per NREQ grants while others are pending.
- **Boundary conditions:**
  - A `div_vld` pulse outside WAIT is ignored.
  - A `req_valid` that rises during RESP is arbitrated in the following IDLE cycle.
  - A `req_valid` that drops without being granted is legal; nothing is latched for it.
  - Assertion of `sys_rst` mid-operation aborts the transaction immediately and produces no response pulse. The divider must be reset by the same reset, inverted at the top level.

## Timing
- Request seen in IDLE at cycle T: `req_ready` is high at T, and the operands are registered at the end of T.
- Nonzero divisor with `div_ready` high: `div_en` at T+1. Divider returns `div_vld` at T+1+L. `rsp_valid` at T+2+L.
- Zero divisor: `rsp_valid` at T+1; the divider is untouched.
- Back-to-back throughput: next grant no earlier than the cycle after RESP.
- `div_en` is never asserted while `div_ready`=0 and is never asserted twice per transaction.

## Configuration
- **Macro `DIV_ARB_TIMEOUT_EN`:**
  - A counter starts at `div_en` and increments every cycle in WAIT.
  - Reaching `TIMEOUT_CYC` without `div_vld` causes RESP with quotient 0, remainder 0 and err = 1.
  - A late `div_vld` that follows is ignored, per the outside-WAIT rule.
- **Without the macro:** no counter is present and WAIT persists until `div_vld`.

## Structure
- **Package `div_arb_pkg`:** the state encoding (IDLE/ISSUE/WAIT/RESP), the default `DATAWIDTH`, the all-ones quotient constant for divide-by-zero, and a function returning the NREQ bit width of `rr_ptr`.
- **Sub-module `div_rr_pick`:** combinational round-robin picker with inputs `req` and `ptr` and outputs one-hot `gnt` and a `found` flag. It is reusable for other shared resources.

## Test plan
All scenarios use a bench divider model with L = 58.
- **Single request, nonzero divisor:** req0 with 100_000_000 / 4_000 → `rsp_valid`=01, quotient 25_000, remainder 0, err 0, arriving 60 cycles after `req_ready`.
- **Simultaneous requests:** req0 and req1 held together from reset → grants alternate 0, 1, 0, 1 over four transactions, and `rsp_valid` one-hot matches each grant.
- **Divide by zero:** req1 with 12345 / 0 → `rsp_valid`=10 one cycle after accept, quotient all-ones, remainder 12345, err 1, and `div_en` never pulses.
- **Divider busy:** hold `div_ready`=0 for 20 cycles after accept → `div_en` is delayed until `div_ready` rises, and the result is correct.
- **Reset mid-WAIT:** assert `sys_rst` 10 cycles after `div_en` → all outputs are 0 and no `rsp_valid` appears. A new request after reset completes normally.
- **Watchdog (`DIV_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=64):** suppress `div_vld` → err response at `div_en`+65 with quotient 0. A late `div_vld` is ignored.
